// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings for the write-back unit, register file and
//               control unit: result sources, load funct3 codes, write-back
//               FSM states and control FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Write-back result source
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_LOAD = 2'b11;

    // Load width / signedness (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Write-back unit FSM
    localparam logic [1:0] WB_IDLE     = 2'd0;
    localparam logic [1:0] WB_WAIT_MEM = 2'd1;
    localparam logic [1:0] WB_DRAIN    = 2'd2;
    localparam logic [1:0] WB_COMMIT   = 2'd3;

    // Control FSM states, shared with register file and control unit
    localparam logic [2:0] CTL_FETCH      = 3'd0;
    localparam logic [2:0] CTL_DECODE     = 3'd1;
    localparam logic [2:0] CTL_EXECUTE    = 3'd2;
    localparam logic [2:0] CTL_MEMORY     = 3'd3;
    localparam logic [2:0] CTL_WRITE_BACK = 3'd4;
    localparam logic [2:0] CTL_TRAP       = 3'd5;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/half/word from an aligned read
//               word, sign- or zero-extends it, and flags misaligned or
//               illegal load encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half out of the read word
    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane and classify the access
    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                data  = {{(XLEN-16){w_half[15]}}, w_half};
                fault = addr_lo[0];
            end
            F3_LHU: begin
                data  = {{(XLEN-16){1'b0}}, w_half};
                fault = addr_lo[0];
            end
            F3_LW: begin
                data  = rdata;
                fault = (addr_lo != 2'd0);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_unit
// Description : Write-back producer for the integer register file. Accepts
//               one request per instruction, waits for load data when
//               needed, and holds the write until the control FSM grants
//               its WRITE_BACK cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [1:0]            issue_src,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [XLEN-1:0]       issue_value,
    input  logic [2:0]            issue_funct3,
    input  logic [1:0]            issue_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  flush,
    input  logic                  wb_grant,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       result,
    output logic                  reg_write,
    output logic                  wb_done,
    output logic                  load_fault,
    output logic                  busy
);

    logic [1:0]            r_state;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_result;
    logic                  r_wen;
    logic [2:0]            r_f3;
    logic [1:0]            r_addr_lo;
    logic                  r_fault;

    logic                  w_accept;
    logic [2:0]            w_la_f3;
    logic [1:0]            w_la_addr;
    logic [XLEN-1:0]       w_la_data;
    logic                  w_la_fault;

    // One aligner serves both jobs: in IDLE it checks the incoming request,
    // in WAIT_MEM it formats the returning data from the latched fields.
    always_comb begin
        w_la_f3   = (r_state == WB_IDLE) ? issue_funct3  : r_f3;
        w_la_addr = (r_state == WB_IDLE) ? issue_addr_lo : r_addr_lo;
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3  (w_la_f3),
        .addr_lo (w_la_addr),
        .rdata   (mem_rdata),
        .data    (w_la_data),
        .fault   (w_la_fault)
    );

    // Handshake and register-file facing outputs
    always_comb begin
        issue_ready = (r_state == WB_IDLE) && !flush;
        w_accept    = issue_valid && issue_ready;
        rd          = r_rd;
        result      = r_result;
        reg_write   = (r_state == WB_COMMIT) && r_wen;
        wb_done     = (r_state == WB_COMMIT) && wb_grant;
        load_fault  = r_fault;
        busy        = (r_state != WB_IDLE);
    end

    // Request tracking FSM; x0 writes are suppressed by clearing r_wen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WB_IDLE;
            r_rd      <= '0;
            r_result  <= '0;
            r_wen     <= 1'b0;
            r_f3      <= 3'b0;
            r_addr_lo <= 2'b0;
            r_fault   <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                WB_IDLE: begin
                    if (w_accept) begin
                        case (issue_src)
                            SRC_LOAD: begin
                                if (w_la_fault) begin
                                    r_fault <= 1'b1;
                                end else begin
                                    r_state   <= WB_WAIT_MEM;
                                    r_rd      <= issue_rd;
                                    r_f3      <= issue_funct3;
                                    r_addr_lo <= issue_addr_lo;
                                    r_wen     <= (issue_rd != '0);
                                end
                            end
                            SRC_NONE: begin
                                r_state <= WB_COMMIT;
                                r_wen   <= 1'b0;
                            end
                            default: begin
                                r_state  <= WB_COMMIT;
                                r_rd     <= issue_rd;
                                r_result <= issue_value;
                                r_wen    <= (issue_rd != '0);
                            end
                        endcase
                    end
                end
                WB_WAIT_MEM: begin
                    // A flush with the response already here needs no drain
                    if (flush) begin
                        r_state <= mem_rvalid ? WB_IDLE : WB_DRAIN;
                    end else if (mem_rvalid) begin
                        r_state  <= WB_COMMIT;
                        r_result <= w_la_data;
                    end
                end
                WB_DRAIN: begin
                    if (mem_rvalid) r_state <= WB_IDLE;
                end
                WB_COMMIT: begin
                    if (wb_grant) r_state <= WB_IDLE;
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

endmodule : wb_unit
`default_nettype wire

// File: tb/tb_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_unit
// Description : Self-checking bench for wb_unit: directed scenarios plus
//               randomized requests against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_src;
    logic [3:0]  issue_rd;
    logic [31:0] issue_value;
    logic [2:0]  issue_funct3;
    logic [1:0]  issue_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_grant;
    logic [3:0]  rd;
    logic [31:0] result;
    logic        reg_write;
    logic        wb_done;
    logic        load_fault;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32), .REG_ADDR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_src     (issue_src),
        .issue_rd      (issue_rd),
        .issue_value   (issue_value),
        .issue_funct3  (issue_funct3),
        .issue_addr_lo (issue_addr_lo),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .flush         (flush),
        .wb_grant      (wb_grant),
        .rd            (rd),
        .result        (result),
        .reg_write     (reg_write),
        .wb_done       (wb_done),
        .load_fault    (load_fault),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: load result from the read word by plain arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (32'(a) * 8)) % 256;
        h = (d >> (32'(a[1]) * 16)) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic bit ref_fault(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One complete request: issue, optional memory response, commit on grant
    task automatic run_req(input logic [1:0] src, input logic [3:0] r, input logic [31:0] val,
                           input logic [2:0] f3, input logic [1:0] a, input logic [31:0] mdata,
                           input int mem_dly, input int gnt_dly, input bit rand_flush);
        bit          exp_fault;
        logic        exp_we;
        logic [31:0] exp_res;
        exp_fault = (src == 2'b11) && ref_fault(f3, a);
        exp_we    = (src != 2'b00) && (r != 0);
        exp_res   = (src == 2'b11) ? ref_load(f3, a, mdata) : val;

        issue_valid = 1'b1; issue_src = src; issue_rd = r; issue_value = val;
        issue_funct3 = f3; issue_addr_lo = a;
        #1;
        chk("ready_idle", {31'b0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        issue_value = $urandom; issue_rd = 4'($urandom);
        if (exp_fault) begin
            chk("fault_pulse", {31'b0, load_fault}, 32'd1);
            chk("fault_busy", {31'b0, busy}, 32'd0);
            chk("fault_we", {31'b0, reg_write}, 32'd0);
            tick();
            chk("fault_clr", {31'b0, load_fault}, 32'd0);
            return;
        end
        chk("no_fault", {31'b0, load_fault}, 32'd0);
        if (src == 2'b11) begin
            for (int i = 0; i < mem_dly; i++) begin
                mem_rdata = $urandom;
                chk("wait_busy", {31'b0, busy}, 32'd1);
                chk("wait_we", {31'b0, reg_write}, 32'd0);
                chk("wait_ready", {31'b0, issue_ready}, 32'd0);
                tick();
            end
            mem_rvalid = 1'b1; mem_rdata = mdata;
            tick();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            wb_grant = (i == gnt_dly);
            flush = rand_flush ? 1'($urandom) : 1'b0;
            #1;
            chk("commit_we", {31'b0, reg_write}, {31'b0, exp_we});
            chk("commit_done", {31'b0, wb_done}, {31'b0, wb_grant});
            if (src != 2'b00) begin
                chk("commit_rd", {28'b0, rd}, {28'b0, r});
                chk("commit_res", result, exp_res);
            end
            tick();
        end
        wb_grant = 1'b0; flush = 1'b0;
        #1;
        chk("post_idle", {31'b0, busy}, 32'd0);
        chk("post_ready", {31'b0, issue_ready}, 32'd1);
        chk("post_we", {31'b0, reg_write}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_src = 2'b00; issue_rd = 4'd0;
        issue_value = 32'd0; issue_funct3 = 3'd0; issue_addr_lo = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0; flush = 1'b0; wb_grant = 1'b0;
        #12;
        chk("rst_rd", {28'b0, rd}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_we", {31'b0, reg_write}, 32'd0);
        chk("rst_done", {31'b0, wb_done}, 32'd0);
        chk("rst_fault", {31'b0, load_fault}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'b0, issue_ready}, 32'd1);

        // Directed cases from the intended use
        run_req(2'b01, 4'd5, 32'hDEADBEEF, 3'd0, 2'd0, 32'd0, 0, 3, 1'b0);
        run_req(2'b11, 4'd7, 32'd0, 3'd0, 2'd3, 32'h80FF1234, 1, 0, 1'b0);
        run_req(2'b11, 4'd8, 32'd0, 3'd5, 2'd2, 32'h80FF1234, 0, 1, 1'b0);
        run_req(2'b11, 4'd9, 32'd0, 3'd2, 2'd0, 32'h80FF1234, 2, 0, 1'b0);
        run_req(2'b11, 4'd9, 32'd0, 3'd1, 2'd1, 32'h80FF1234, 0, 0, 1'b0);
        run_req(2'b11, 4'd9, 32'd0, 3'd3, 2'd0, 32'h80FF1234, 0, 0, 1'b0);
        run_req(2'b01, 4'd0, 32'h12345678, 3'd0, 2'd0, 32'd0, 0, 2, 1'b0);
        run_req(2'b00, 4'd4, 32'h12345678, 3'd0, 2'd0, 32'd0, 0, 1, 1'b0);
        run_req(2'b10, 4'd1, 32'h00000104, 3'd0, 2'd0, 32'd0, 0, 0, 1'b1);

        // Flush in IDLE blocks acceptance
        issue_valid = 1'b1; issue_src = 2'b01; issue_rd = 4'd3; flush = 1'b1;
        #1;
        chk("flush_idle_ready", {31'b0, issue_ready}, 32'd0);
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'b0, busy}, 32'd0);

        // Flush while waiting for memory: drain, then back to IDLE silently
        issue_valid = 1'b1; issue_src = 2'b11; issue_rd = 4'd6;
        issue_funct3 = 3'd2; issue_addr_lo = 2'd0;
        tick();
        issue_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_busy", {31'b0, busy}, 32'd1);
            chk("drain_ready", {31'b0, issue_ready}, 32'd0);
            chk("drain_we", {31'b0, reg_write}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;
        chk("drain_exit_busy", {31'b0, busy}, 32'd0);
        chk("drain_exit_ready", {31'b0, issue_ready}, 32'd1);
        chk("drain_exit_we", {31'b0, reg_write}, 32'd0);
        chk("drain_exit_done", {31'b0, wb_done}, 32'd0);

        // Flush coinciding with the response: straight back to IDLE
        issue_valid = 1'b1; issue_src = 2'b11; issue_rd = 4'd6;
        tick();
        issue_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush_rv_busy", {31'b0, busy}, 32'd0);
        chk("flush_rv_we", {31'b0, reg_write}, 32'd0);

        // Asynchronous reset in the middle of a load
        issue_valid = 1'b1; issue_src = 2'b11; issue_rd = 4'd3;
        issue_funct3 = 3'd2; issue_addr_lo = 2'd0;
        tick();
        issue_valid = 1'b0;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_rd", {28'b0, rd}, 32'd0);
        chk("arst_res", result, 32'd0);
        #1 rst = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_rvalid = 1'b0;
        chk("arst_late_busy", {31'b0, busy}, 32'd0);
        chk("arst_late_we", {31'b0, reg_write}, 32'd0);

        // Randomized requests
        for (int k = 0; k < 300; k++) begin
            run_req(2'($urandom), 4'($urandom), $urandom, 3'($urandom), 2'($urandom),
                    $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_unit
`default_nettype wire

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back producer for the integer register file; the only source of its rd/result/reg_write write port.
- Accepts one write-back request per instruction from EXECUTE: ALU result, PC+4 link value, load, or no-write.
- For loads, waits for the memory read response, then extracts and sign/zero-extends the data.
- Presents a stable write to the register file and holds it until the control FSM grants its WRITE_BACK cycle.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 4, register index width (x0..x15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  write-back request present
- issue_ready  out  1  unit can accept a request
- issue_src  in  2  00 NONE, 01 ALU, 10 PC4, 11 LOAD
- issue_rd  in  REG_ADDR_W  destination register
- issue_value  in  XLEN  ALU result or PC+4
- issue_funct3  in  3  load width/sign (LOAD only)
- issue_addr_lo  in  2  load byte address [1:0] (LOAD only)
- mem_rvalid  in  1  load data valid, one-cycle pulse
- mem_rdata  in  XLEN  aligned 32-bit read word
- flush  in  1  abandon pending request (trap/redirect)
- wb_grant  in  1  control FSM is in WRITE_BACK this cycle
- rd  out  REG_ADDR_W  register-file write index
- result  out  XLEN  register-file write data
- reg_write  out  1  register-file write enable
- wb_done  out  1  commit completed this cycle
- load_fault  out  1  misaligned or illegal load, one-cycle pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state): state IDLE; rd=0, result=0, reg_write=0, wb_done=0, load_fault=0; issue_ready=1 once rst deasserts.
- States: IDLE, WAIT_MEM, DRAIN, COMMIT.
- issue_ready = (state==IDLE) && !flush. A request is accepted on a cycle where issue_valid && issue_ready.
- IDLE, accepting ALU/PC4 -> COMMIT next cycle: result=issue_value, rd=issue_rd.
- IDLE, accepting NONE -> COMMIT with reg_write=0 (only wb_done is produced).
- IDLE, accepting LOAD, legal and aligned -> WAIT_MEM; rd, funct3 and addr_lo are latched.
- IDLE, accepting LOAD, misaligned or illegal -> load_fault=1 for the following cycle; state stays IDLE; no write, no wb_done.
  - Misaligned: LH/LHU with addr_lo[0]=1; LW with addr_lo!=0.
  - Illegal: funct3 of 011, 110 or 111.
- WAIT_MEM, on mem_rvalid -> COMMIT; result is the formatted data:
  - LB: sign-extend byte mem_rdata[8*addr_lo +: 8]; LBU zero-extends the same byte.
  - LH: sign-extend half mem_rdata[16*addr_lo[1] +: 16]; LHU zero-extends the same half.
  - LW: mem_rdata unchanged.
- WAIT_MEM with flush -> DRAIN (flush wins over a same-cycle mem_rvalid, which is discarded and goes to IDLE instead).
- DRAIN, on mem_rvalid -> IDLE; data discarded, no write.
- COMMIT:
  - rd and result are held stable.
  - reg_write = 1 iff source != NONE and rd != 0.
  - Stays in COMMIT until wb_grant. On the grant cycle: wb_done=1 (combinational with wb_grant), register file captures on that edge, next state IDLE.
  - flush is ignored in COMMIT; the commit is already architecturally due.
- flush in IDLE blocks acceptance that cycle.
- Latency, no stalls: ALU/PC4 commit-ready 1 cycle after accept; LOAD commit-ready 1 cycle after mem_rvalid.
- Back-to-back: a new request can be accepted the cycle after wb_done.
- Writes to x0 are never asserted on reg_write.

Decomposition:
- Shared package wb_pkg:
  - source encodings SRC_NONE/ALU/PC4/LOAD;
  - load funct3 constants F3_LB/LH/LW/LBU/LHU;
  - wb state encoding;
  - control FSM state constants FETCH..TRAP, shared with the register file and control unit.
- One combinational sub-module, load_align: funct3, addr_lo, rdata -> formatted data and fault flag. It is reused for the issue-time fault check and for the WAIT_MEM formatting.

Test Plan:
- Reset mid-WAIT_MEM: assert rst asynchronously -> outputs zero immediately, busy=0; a later mem_rvalid causes no write.
- ALU to x5, value 0xDEADBEEF; wb_grant held low 3 cycles, then high -> reg_write=1, rd=5, result stable for 4 cycles; wb_done only on the grant cycle.
- LOAD LB addr_lo=3, mem_rdata=0x80FF_1234 -> result 0xFFFFFF80. LHU addr_lo=2, same data -> 0x000080FF. LW -> 0x80FF1234.
- LH addr_lo=1 -> load_fault pulse; no WAIT_MEM, no reg_write. funct3=011 -> load_fault.
- LOAD, flush in WAIT_MEM, then mem_rvalid 2 cycles later -> DRAIN, then IDLE; no reg_write, no wb_done; issue_ready returns after the rvalid.
- ALU with rd=0, and NONE source -> reg_write=0 throughout, wb_done=1 on grant.
